// File: rtl/interlock_trip_latch.sv
// Latched RF permit from the card6 interlock outputs: debounces the slow faults, trips on the
// first fault, enforces a holdoff, and re-arms only on an operator reset edge.
module interlock_trip_latch #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLDOFF_CYCLES  = 1000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_I_AN_HIGH,
  input  logic       i_Emergency,
  input  logic       i_Not_Alarm,
  input  logic       i_Operator_Reset,
  output logic       o_RF_Permit,
  output logic       o_Tripped,
  output logic [2:0] o_First_Fault,
  output logic [7:0] o_Trip_Count
);

  localparam logic [CNT_W-1:0] DebMax  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    StWaitClear = 2'b00,
    StArmed     = 2'b01,
    StTripped   = 2'b10
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      hold_cnt_q;
  logic                  op_reset_q;
  logic                  rst_edge;
  logic                  fault_any;

  // Channel 0 = anode over-current, channel 1 = alarm (Not_Alarm is active low).
  logic [1:0]            raw_fault;
  logic [1:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]            deb_q, deb_d;

  assign raw_fault = {~i_Not_Alarm, i_I_AN_HIGH};

  always_comb begin
    deb_cnt_d = '0;
    deb_d     = '0;
    for (int i = 0; i < 2; i++) begin
      if (raw_fault[i]) begin
        deb_cnt_d[i] = (deb_cnt_q[i] >= DebMax) ? DebMax : deb_cnt_q[i] + 1'b1;
        deb_d[i]     = (deb_cnt_d[i] == DebMax);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt_q  <= '0;
      deb_q      <= '0;
      op_reset_q <= 1'b0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      deb_q      <= deb_d;
      op_reset_q <= i_Operator_Reset;
    end
  end

  assign rst_edge  = i_Operator_Reset & ~op_reset_q;
  // Emergency bypasses the debounce so it trips on the very next edge.
  assign fault_any = (|deb_q) | i_Emergency;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StWaitClear;
      hold_cnt_q    <= '0;
      o_RF_Permit   <= 1'b0;
      o_Tripped     <= 1'b0;
      o_First_Fault <= 3'b000;
      o_Trip_Count  <= 8'd0;
    end else begin
      case (state_q)
        StWaitClear: begin
          if (!fault_any) begin
            state_q       <= StArmed;
            o_RF_Permit   <= 1'b1;
            o_First_Fault <= 3'b000;
          end
        end
        StArmed: begin
          if (fault_any) begin
            state_q       <= StTripped;
            o_RF_Permit   <= 1'b0;
            o_Tripped     <= 1'b1;
            o_First_Fault <= {deb_q[1], i_Emergency, deb_q[0]};
            hold_cnt_q    <= '0;
            if (o_Trip_Count != 8'hFF) begin
              o_Trip_Count <= o_Trip_Count + 8'd1;
            end
          end
        end
        StTripped: begin
          if (hold_cnt_q != HoldMax) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
          // Edges seen before the holdoff expires are dropped, not queued.
          if (rst_edge && (hold_cnt_q == HoldMax)) begin
            state_q   <= StWaitClear;
            o_Tripped <= 1'b0;
          end
        end
        default: begin
          state_q     <= StWaitClear;
          o_RF_Permit <= 1'b0;
          o_Tripped   <= 1'b0;
        end
      endcase
    end
  end

endmodule
